// File: rtl/cnn_cls_pkg.sv
// Shared parameters and helpers for the cnn_classifier_learn head:
// W1 connectivity, W2 initial values and int8 saturating update.
package cnn_cls_pkg;

   localparam int unsigned N_FEAT    = 80;
   localparam int unsigned FEAT_W    = 8;
   localparam int unsigned N_HID     = 16;
   localparam int unsigned N_CLASS   = 8;
   localparam int unsigned LABEL_W   = 8;
   localparam int unsigned HID_ACC_W = 18;
   localparam int unsigned LOGIT_W   = 24;
   localparam int unsigned W_W       = 8;
   localparam int unsigned HID_W     = 8;
   localparam int unsigned IDX_W     = $clog2(N_CLASS);

   localparam logic [LABEL_W-1:0] ANOMALY_CLASS = 8'hFF;
   localparam logic [HID_W-1:0]   HID_MAX       = 8'd127;

   typedef logic signed [W_W-1:0] w8_t;

   // FC1 is a fixed fold: hidden h sums every feature whose index is h mod N_HID
   function automatic logic w1_coef(input int unsigned h, input int unsigned i);
      return (i % N_HID) == h;
   endfunction

   function automatic w8_t w2_init(input int unsigned c, input int unsigned h);
      return (c == h) ? W_W'(c + 1) : '0;
   endfunction

   // a +/- d clamped to the int8 range; d is a non-negative hidden activation
   function automatic w8_t sat_add8(input w8_t a, input logic [HID_W-1:0] d, input logic neg);
      logic signed [W_W+1:0] aa;
      logic signed [W_W+1:0] dd;
      logic signed [W_W+1:0] s;
      aa = (W_W+2)'(a);
      dd = signed'({2'b00, d});
      s  = neg ? (aa - dd) : (aa + dd);
      if (s > 10'sd127)       return 8'sd127;
      else if (s < -10'sd128) return -8'sd128;
      else                    return W_W'(s);
   endfunction

endpackage

// File: rtl/cnn_cls_argmax.sv
// Combinational argmax over N_CLASS signed logits; ties go to the lowest index.
module cnn_cls_argmax
   import cnn_cls_pkg::*;
(
   input  logic signed [LOGIT_W-1:0] i_logit [N_CLASS],
   output logic        [IDX_W-1:0]   o_idx_c
);

   logic signed [LOGIT_W-1:0] w_best;

   // strict greater-than keeps the earliest maximum
   always_comb begin
      w_best  = i_logit[0];
      o_idx_c = '0;
      for (int unsigned c = 1; c < N_CLASS; c++) begin
         if (i_logit[c] > w_best) begin
            w_best  = i_logit[c];
            o_idx_c = IDX_W'(c);
         end
      end
   end

endmodule

// File: rtl/cnn_classifier_learn.sv
// FC1(fixed)+ReLU -> FC2(int8) -> argmax classifier head with anomaly override.
// Define CNN_CLS_LEARN_EN for online perceptron learning of the FC2 weights.
module cnn_classifier_learn
   import cnn_cls_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_FEAT*FEAT_W-1:0]   features_in_flat,
   input  logic [LABEL_W-1:0]         label_in,
   input  logic                       label_in_valid,
   input  logic                       anomaly_flag,
   output logic [LABEL_W-1:0]         class_label
);

   logic [N_FEAT*FEAT_W-1:0]  r_feat;
   logic [HID_W-1:0]          r_hid   [N_HID];
   logic signed [LOGIT_W-1:0] r_logit [N_CLASS];
   logic [IDX_W-1:0]          r_pred;
   logic [LABEL_W-1:0]        r_class;

   logic signed [HID_ACC_W-1:0] w_acc   [N_HID];
   logic [HID_W-1:0]            w_hid   [N_HID];
   logic signed [LOGIT_W-1:0]   w_logit [N_CLASS];
   w8_t                         w_w2    [N_CLASS][N_HID];
   logic [IDX_W-1:0]            w_pred;

   // FC1 with ReLU clamp to [0,127]
   always_comb begin
      for (int unsigned h = 0; h < N_HID; h++) begin
         w_acc[h] = '0;
         for (int unsigned i = 0; i < N_FEAT; i++) begin
            if (w1_coef(h, i))
               w_acc[h] = w_acc[h] + HID_ACC_W'(signed'(r_feat[i*FEAT_W +: FEAT_W]));
         end
         if (w_acc[h][HID_ACC_W-1])                    w_hid[h] = '0;
         else if (|w_acc[h][HID_ACC_W-2:HID_W-1])      w_hid[h] = HID_MAX;
         else                                          w_hid[h] = {1'b0, w_acc[h][HID_W-2:0]};
      end
   end

   always_comb begin
      for (int unsigned c = 0; c < N_CLASS; c++) begin
         w_logit[c] = '0;
         for (int unsigned h = 0; h < N_HID; h++) begin
            w_logit[c] = w_logit[c]
                       + LOGIT_W'(w_w2[c][h]) * LOGIT_W'(signed'({1'b0, r_hid[h]}));
         end
      end
   end

   cnn_cls_argmax u_argmax (
      .i_logit (r_logit),
      .o_idx_c (w_pred)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_feat  <= '0;
         r_hid   <= '{default: '0};
         r_logit <= '{default: '0};
         r_pred  <= '0;
         r_class <= '0;
      end else begin
         r_feat  <= features_in_flat;
         r_hid   <= w_hid;
         r_logit <= w_logit;
         r_pred  <= w_pred;
         r_class <= anomaly_flag ? ANOMALY_CLASS : LABEL_W'(w_pred);
      end
   end

   assign class_label = r_class;

`ifdef CNN_CLS_LEARN_EN
   w8_t              r_w2 [N_CLASS][N_HID];
   logic             r_lv;
   logic             w_learn;
   logic [IDX_W-1:0] w_lbl;

   assign w_lbl   = label_in[IDX_W-1:0];
   assign w_learn = label_in_valid && !r_lv && !anomaly_flag
                 && (label_in < LABEL_W'(N_CLASS)) && (w_lbl != r_pred);

   // an anomaly-masked edge still updates r_lv, so it is consumed
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lv <= 1'b0;
         for (int unsigned c = 0; c < N_CLASS; c++)
            for (int unsigned h = 0; h < N_HID; h++)
               r_w2[c][h] <= w2_init(c, h);
      end else begin
         r_lv <= label_in_valid;
         if (w_learn) begin
            for (int unsigned h = 0; h < N_HID; h++) begin
               r_w2[w_lbl][h]  <= sat_add8(r_w2[w_lbl][h], r_hid[h], 1'b0);
               r_w2[r_pred][h] <= sat_add8(r_w2[r_pred][h], r_hid[h], 1'b1);
            end
         end
      end
   end

   assign w_w2 = r_w2;
`else
   logic w_unused;
   assign w_unused = ^{label_in, label_in_valid};

   always_comb begin
      for (int unsigned c = 0; c < N_CLASS; c++)
         for (int unsigned h = 0; h < N_HID; h++)
            w_w2[c][h] = w2_init(c, h);
   end
`endif

endmodule

// File: tb/tb_cnn_classifier_learn.sv
// Directed bench for cnn_classifier_learn; learning expectations follow CNN_CLS_LEARN_EN.
module tb_cnn_classifier_learn;

`ifdef CNN_CLS_LEARN_EN
   localparam bit LEARN = 1'b1;
`else
   localparam bit LEARN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [639:0] features_in_flat;
   logic [7:0]   label_in;
   logic         label_in_valid;
   logic         anomaly_flag;
   logic [7:0]   class_label;

   int n_tests = 0;
   int n_fail  = 0;

   cnn_classifier_learn dut (
      .clk              (clk),
      .rst              (rst),
      .features_in_flat (features_in_flat),
      .label_in         (label_in),
      .label_in_valid   (label_in_valid),
      .anomaly_flag     (anomaly_flag),
      .class_label      (class_label)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] exp);
      n_tests++;
      assert (class_label === exp)
      else begin
         n_fail++;
         $error("FAIL %s: class_label=%h expected=%h", tag, class_label, exp);
      end
   endtask

   task automatic set_all(input logic [7:0] v);
      for (int i = 0; i < 80; i++) features_in_flat[i*8 +: 8] = v;
   endtask

   initial begin
      rst = 1'b1; label_in = 8'd0; label_in_valid = 1'b0; anomaly_flag = 1'b0;
      set_all(8'h00);
      tick(5);
      check("rst_hold", 8'h00);

      rst = 1'b0;
      tick(5);
      check("zero_feat_tie", 8'h00);

      // hid=5 each, logit[c]=5(c+1)
      set_all(8'h01);
      tick(2);
      check("lat_early", 8'h00);
      tick(2);
      check("ones", 8'h07);

      anomaly_flag = 1'b1;
      tick(1);
      check("anom_on", 8'hFF);
      label_in = 8'd3; label_in_valid = 1'b1;
      tick(18);
      check("anom_hold", 8'hFF);
      anomaly_flag = 1'b0;
      tick(1);
      check("anom_off", 8'h07);
      tick(5);
      check("anom_edge_consumed", 8'h07);
      label_in_valid = 1'b0;
      tick(2);

      // one update: logit3=420, logit7=-360
      label_in_valid = 1'b1;
      tick(4);
      check("learn", LEARN ? 8'h03 : 8'h07);
      tick(16);
      check("learn_hold", LEARN ? 8'h03 : 8'h07);
      label_in_valid = 1'b0;
      tick(2);

      // hid6=127 only: logit6=889 beats logit3=635 unless W2[3][6] grew past 5
      set_all(8'h00);
      for (int i = 6; i < 80; i += 16) features_in_flat[i*8 +: 8] = 8'h7F;
      tick(5);
      check("one_update", 8'h06);

      set_all(8'h01);
      label_in = 8'd0; label_in_valid = 1'b1; rst = 1'b1;
      tick(10);
      check("rst_mid", 8'h00);
      rst = 1'b0; label_in_valid = 1'b0;
      tick(5);
      check("reinit", 8'h07);

      // hid3=2, hid7=1: logit3=logit7=8
      set_all(8'h00);
      features_in_flat[3*8 +: 8] = 8'h02;
      features_in_flat[7*8 +: 8] = 8'h01;
      tick(5);
      check("tie_low", 8'h03);

      set_all(8'h01);
      tick(2);
      label_in = 8'd9; label_in_valid = 1'b1;
      tick(6);
      check("label_oob", 8'h07);
      label_in_valid = 1'b0;

      set_all(8'hFF);
      tick(5);
      check("neg_relu", 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
